inv_sbox_layer: RTL

Sequential inverse of the Ascon substitution layer. It accepts a 320-bit Ascon state, applies the inverse 5-bit S-box to each of the 64 bit-sliced columns, COLS_PER_CYCLE columns per clock, and returns the substituted state with a done pulse. It sits in the decryption/verification datapath and is the counterpart of the forward substitution layer used in the permutation.

---
 rtl/inv_sbox_layer_pkg.sv | 34 +++
 rtl/inv_sbox_layer_inv_sbox.sv | 14 +
 rtl/inv_sbox_layer.sv | 110 +++++++++++
 3 files changed

// File: rtl/inv_sbox_layer_pkg.sv
// Shared Ascon definitions: the state type, the forward and inverse 5-bit
// S-box tables, and the substitution layer FSM encoding.
package ascon_pack;

  localparam int unsigned NCOLS = 64;

  // x0..x4, x0 at index 0 so that x0 supplies the column MSB
  typedef logic [0:4][63:0] type_state;

  typedef enum logic {IDLE, BUSY} type_fsm;

  localparam logic [0:31][4:0] SBOX = {
    5'h04, 5'h0B, 5'h1F, 5'h14, 5'h1A, 5'h15, 5'h09, 5'h02,
    5'h1B, 5'h05, 5'h08, 5'h12, 5'h1D, 5'h03, 5'h06, 5'h1C,
    5'h1E, 5'h13, 5'h07, 5'h0E, 5'h00, 5'h0D, 5'h11, 5'h18,
    5'h10, 5'h0C, 5'h01, 5'h19, 5'h16, 5'h0A, 5'h0F, 5'h17
  };

  localparam logic [0:31][4:0] INV_SBOX = {
    5'h14, 5'h1A, 5'h07, 5'h0D, 5'h00, 5'h09, 5'h0E, 5'h12,
    5'h0A, 5'h06, 5'h1D, 5'h01, 5'h19, 5'h15, 5'h13, 5'h1E,
    5'h18, 5'h16, 5'h0B, 5'h11, 5'h03, 5'h05, 5'h1C, 5'h1F,
    5'h17, 5'h1B, 5'h04, 5'h08, 5'h0F, 5'h0C, 5'h10, 5'h02
  };

  function automatic logic [4:0] sbox_fwd(input logic [4:0] x);
    return SBOX[x];
  endfunction

  function automatic logic [4:0] sbox_inv(input logic [4:0] x);
    return INV_SBOX[x];
  endfunction

endpackage

// File: rtl/inv_sbox_layer_inv_sbox.sv
// Combinational inverse Ascon S-box for one bit-sliced column.
module inv_sbox
  import ascon_pack::*;
(
  input  logic [4:0] i_col,
  output logic [4:0] o_col
);

  // table lookup, x0 is the MSB of both input and output
  always_comb begin
    o_col = sbox_inv(i_col);
  end

endmodule

// File: rtl/inv_sbox_layer.sv
// Sequential inverse Ascon substitution layer: COLS_PER_CYCLE columns of the
// captured 320-bit state are substituted in place per clock, with a one-cycle
// done pulse once all 64 columns have been processed.
module inv_sbox_layer
  import ascon_pack::*;
#(
  parameter int unsigned COLS_PER_CYCLE = 8
) (
  input  logic      clock_i,
  input  logic      resetb_i,
  input  logic      start_i,
  input  type_state state_i,
  output logic      ready_o,
  output logic      done_o,
  output type_state state_o
);

  localparam int unsigned      NGROUPS  = NCOLS / COLS_PER_CYCLE;
  localparam int unsigned      CNT_W    = (NGROUPS > 1) ? $clog2(NGROUPS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NGROUPS - 1);

  type_fsm          r_fsm;
  logic [CNT_W-1:0] r_cnt;
  type_state        r_state;
  logic             r_ready;
  logic             r_done;

  logic [5:0]                     w_base;
  logic [0:4][COLS_PER_CYCLE-1:0] w_plane;
  type_state                      w_next;

  // first column of the group selected by the counter
  assign w_base = 6'(32'(r_cnt) * COLS_PER_CYCLE);

  // one S-box per column of the current group; results are regrouped into
  // per-row slices so the write-back below is a plain part-select
  for (genvar g = 0; g < COLS_PER_CYCLE; g++) begin : g_col
    logic [5:0] w_j;
    logic [4:0] w_in;
    logic [4:0] w_out;

    assign w_j  = w_base + 6'(g);
    assign w_in = {r_state[0][w_j], r_state[1][w_j], r_state[2][w_j],
                   r_state[3][w_j], r_state[4][w_j]};

    inv_sbox u_inv_sbox (
      .i_col (w_in),
      .o_col (w_out)
    );

    assign w_plane[0][g] = w_out[4];
    assign w_plane[1][g] = w_out[3];
    assign w_plane[2][g] = w_out[2];
    assign w_plane[3][g] = w_out[1];
    assign w_plane[4][g] = w_out[0];
  end

  // state with the current group of columns replaced by their substitutes
  always_comb begin
    w_next = r_state;
    w_next[0][w_base +: COLS_PER_CYCLE] = w_plane[0];
    w_next[1][w_base +: COLS_PER_CYCLE] = w_plane[1];
    w_next[2][w_base +: COLS_PER_CYCLE] = w_plane[2];
    w_next[3][w_base +: COLS_PER_CYCLE] = w_plane[3];
    w_next[4][w_base +: COLS_PER_CYCLE] = w_plane[4];
  end

  // control FSM with registered ready/done and in-place state update
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_fsm   <= IDLE;
      r_cnt   <= '0;
      r_state <= '0;
      r_ready <= 1'b1;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      unique case (r_fsm)
        IDLE: begin
          if (start_i) begin
            r_state <= state_i;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_fsm   <= BUSY;
          end
        end
        BUSY: begin
          r_state <= w_next;
          if (r_cnt == CNT_LAST) begin
            r_cnt   <= '0;
            r_done  <= 1'b1;
            r_ready <= 1'b1;
            r_fsm   <= IDLE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_fsm   <= IDLE;
          r_ready <= 1'b1;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign done_o  = r_done;
  assign state_o = r_state;

endmodule
